// File: rtl/vseq_pkg.sv
// Shared definitions for the vector instruction sequencer.
// Contents: instruction field positions, the instruction word type, the issue
// FSM state type, and a helper that detects a store reading an ALU result
// register right after an ALU op.
package vseq_pkg;

    localparam int unsigned INSTR_W    = 13;
    localparam int unsigned OP_ALU_BIT = 12;
    localparam int unsigned OP_SEL_BIT = 11;
    localparam int unsigned REG_MSB    = 10;
    localparam int unsigned REG_LSB    = 9;
    localparam int unsigned ADDR_MSB   = 8;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // A store (bits[12:11]=01) of reg 2 or 3 (reg MSB set) that directly
    // follows an ALU op must wait for the ALU result to settle.
    function automatic logic is_raw_store(instr_t w, logic last_alu);
        return last_alu && !w[OP_ALU_BIT] && w[OP_SEL_BIT] && w[REG_MSB];
    endfunction

endpackage

// File: rtl/vseq_fifo.sv
// Parameterised synchronous FIFO with asynchronous active-low reset.
// Ports: clk, reset (async, active-low), push/din (write), pop (read advance),
// head (current oldest entry), count (occupancy, one extra bit so full and
// empty differ), full, empty. The caller never pushes when full and never
// pops when empty.
module vseq_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/vector_instr_sequencer.sv
// Issue stage for the vector core: buffers host instructions in a FIFO and
// presents each one on instr_out for a fixed dwell so the core's multi-cycle
// load/store/ALU sequence finishes before the next word appears.
// Ports:
//   clk, reset (async, active-low)
//   push_valid/push_instr/push_ready : host write handshake
//   run        : issue enable; dropping it pauses after the current dwell
//   instr_out  : word driven to the core (holds last issued word when idle)
//   issuing    : high while a word is within its dwell
//   fifo_count : FIFO occupancy
//   issued_cnt : instructions that completed their dwell (wraps)
//   idle       : FIFO empty and not issuing
// Optional: define VSEQ_RAW_STALL_EN to stretch the dwell of a store of
// reg 2/3 that directly follows an ALU op by two clocks.
module vector_instr_sequencer
    import vseq_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_valid,
    input  logic [12:0]            push_instr,
    output logic                   push_ready,
    input  logic                   run,
    output logic [12:0]            instr_out,
    output logic                   issuing,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]       issued_cnt,
    output logic                   idle
);

    localparam int unsigned DW_W = $clog2(HOLD_CYCLES + 2) + 1;

    state_t          state;
    logic [DW_W-1:0] dwell;
    instr_t          head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push_c;
    logic            pop_c;
    logic [DW_W-1:0] dwell_load_c;

    // Handshake and status derived from registered state only.
    assign push_ready = !fifo_full;
    assign push_c     = push_valid && push_ready;
    assign idle       = (fifo_count == '0) && !issuing;

    // Pop from IDLE, or back-to-back at the last clock of a dwell.
    always_comb begin
        pop_c = 1'b0;
        if (run && !fifo_empty) begin
            if (state == IDLE) begin
                pop_c = 1'b1;
            end else if (dwell == '0) begin
                pop_c = 1'b1;
            end
        end
    end

`ifdef VSEQ_RAW_STALL_EN
    logic last_alu;

    // Dwell reload value; RAW stores get two extra clocks.
    always_comb begin
        dwell_load_c = DW_W'(HOLD_CYCLES - 1);
        if (is_raw_store(head, last_alu)) begin
            dwell_load_c = DW_W'(HOLD_CYCLES + 1);
        end
    end

    // Remembers whether the most recently issued word was an ALU op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_alu <= 1'b0;
        end else if (pop_c) begin
            last_alu <= head[OP_ALU_BIT];
        end
    end
`else
    assign dwell_load_c = DW_W'(HOLD_CYCLES - 1);
`endif

    vseq_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .din   (push_instr),
        .pop   (pop_c),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Issue FSM with dwell counter and completion counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dwell      <= '0;
            instr_out  <= '0;
            issuing    <= 1'b0;
            issued_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        instr_out <= head;
                        dwell     <= dwell_load_c;
                        issuing   <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (dwell != '0) begin
                        dwell <= dwell - DW_W'(1);
                    end else begin
                        issued_cnt <= issued_cnt + CNT_W'(1);
                        if (pop_c) begin
                            instr_out <= head;
                            dwell     <= dwell_load_c;
                        end else begin
                            issuing <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    issuing <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_instr_sequencer.sv
// Self-checking bench for vector_instr_sequencer. A second instance with
// HOLD_CYCLES=1 and CNT_W=4 covers single-clock dwells and counter wrap.
module tb_vector_instr_sequencer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned CNT_W = 16;

    logic        clk;
    logic        reset;
    logic        push_valid;
    logic [12:0] push_instr;
    logic        push_ready;
    logic        run;
    logic [12:0] instr_out;
    logic        issuing;
    logic [4:0]  fifo_count;
    logic [15:0] issued_cnt;
    logic        idle;

    logic        w_push_valid;
    logic [12:0] w_push_instr;
    logic        w_push_ready;
    logic        w_run;
    logic [12:0] w_instr_out;
    logic        w_issuing;
    logic [4:0]  w_fifo_count;
    logic [3:0]  w_issued_cnt;
    logic        w_idle;

    int n_checks;
    int n_fail;

    vector_instr_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .push_valid(push_valid), .push_instr(push_instr),
        .push_ready(push_ready), .run(run), .instr_out(instr_out), .issuing(issuing),
        .fifo_count(fifo_count), .issued_cnt(issued_cnt), .idle(idle)
    );

    vector_instr_sequencer #(.DEPTH(16), .HOLD_CYCLES(1), .CNT_W(4)) dutw (
        .clk(clk), .reset(reset), .push_valid(w_push_valid), .push_instr(w_push_instr),
        .push_ready(w_push_ready), .run(w_run), .instr_out(w_instr_out), .issuing(w_issuing),
        .fifo_count(w_fifo_count), .issued_cnt(w_issued_cnt), .idle(w_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b0;
        push_valid = 1'b0; push_instr = '0; run = 1'b0;
        w_push_valid = 1'b0; w_push_instr = '0; w_run = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        push_valid = 1'b0; push_instr = '0; run = 1'b0;
        w_push_valid = 1'b0; w_push_instr = '0; w_run = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (instr_out !== 13'h0) begin n_fail++; $display("FAIL reset_instr_out got %h exp 0000", instr_out); end
        n_checks++; if (issuing !== 1'b0) begin n_fail++; $display("FAIL reset_issuing got %b exp 0", issuing); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
        n_checks++; if (issued_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_issued_cnt got %0d exp 0", issued_cnt); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", idle); end
        n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready got %b exp 1", push_ready); end
        n_checks++; if (w_push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_w_push_ready got %b exp 1", w_push_ready); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [12:0] w [3];
        logic [12:0] exp_w;
        w[0] = 13'h0005; w[1] = 13'h0205; w[2] = 13'h1000;
        apply_reset();
        run = 1'b1;
        for (int t = 0; t <= 13; t++) begin
            @(negedge clk);
            push_valid = (t < 3);
            if (t < 3) push_instr = w[t];
            @(posedge clk); #1;
            if (t >= 1 && t <= 12) begin
                exp_w = w[(t - 1) / 4];
                n_checks++; if (instr_out !== exp_w) begin n_fail++; $display("FAIL b2b_instr_out t=%0d got %h exp %h", t, instr_out, exp_w); end
                n_checks++; if (issuing !== 1'b1) begin n_fail++; $display("FAIL b2b_issuing t=%0d got %b exp 1", t, issuing); end
            end
        end
        push_valid = 1'b0;
        n_checks++; if (issued_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_issued_cnt got %0d exp 3", issued_cnt); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got %b exp 1", idle); end
        n_checks++; if (instr_out !== w[2]) begin n_fail++; $display("FAIL b2b_hold_last got %h exp %h", instr_out, w[2]); end
    endtask

    task automatic test_reset_mid_dwell();
        logic [12:0] w [3];
        w[0] = 13'h0011; w[1] = 13'h0222; w[2] = 13'h0033;
        apply_reset();
        run = 1'b1;
        for (int t = 0; t <= 2; t++) begin
            @(negedge clk);
            push_valid = 1'b1; push_instr = w[t];
            @(posedge clk); #1;
        end
        push_valid = 1'b0;
        n_checks++; if (instr_out !== w[0]) begin n_fail++; $display("FAIL mid_pre_instr_out got %h exp %h", instr_out, w[0]); end
        reset = 1'b0;
        #1;
        n_checks++; if (instr_out !== 13'h0) begin n_fail++; $display("FAIL mid_instr_out got %h exp 0000", instr_out); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL mid_fifo_count got %0d exp 0", fifo_count); end
        n_checks++; if (issued_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_issued_cnt got %0d exp 0", issued_cnt); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle got %b exp 1", idle); end
        n_checks++; if (issuing !== 1'b0) begin n_fail++; $display("FAIL mid_issuing got %b exp 0", issuing); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_full_fifo();
        logic [12:0] w [DEPTH];
        int exp_cnt;
        for (int k = 0; k < DEPTH; k++) w[k] = {2'b00, 11'($urandom)};
        apply_reset();
        run = 1'b0;
        for (int t = 0; t <= DEPTH; t++) begin
            @(negedge clk);
            push_valid = 1'b1;
            if (t < DEPTH) push_instr = w[t]; else push_instr = 13'h1FFF;
            @(posedge clk); #1;
            exp_cnt = (t < DEPTH) ? t + 1 : DEPTH;
            n_checks++; if (fifo_count !== 5'(exp_cnt)) begin n_fail++; $display("FAIL full_count t=%0d got %0d exp %0d", t, fifo_count, exp_cnt); end
            n_checks++; if (push_ready !== (exp_cnt != DEPTH)) begin n_fail++; $display("FAIL full_ready t=%0d got %b", t, push_ready); end
            n_checks++; if (instr_out !== 13'h0) begin n_fail++; $display("FAIL full_noissue t=%0d got %h exp 0000", t, instr_out); end
        end
        @(negedge clk);
        push_valid = 1'b0; run = 1'b1;
        n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_popcycle got %b exp 0", push_ready); end
        @(posedge clk); #1;
        n_checks++; if (fifo_count !== 5'd15) begin n_fail++; $display("FAIL full_after_pop_count got %0d exp 15", fifo_count); end
        n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop_ready got %b exp 1", push_ready); end
        n_checks++; if (instr_out !== w[0]) begin n_fail++; $display("FAIL full_first_pop got %h exp %h", instr_out, w[0]); end
        for (int r = 1; r <= 4 * DEPTH; r++) begin
            @(posedge clk); #1;
            if ((r % 4) == 0 && (r / 4) < DEPTH) begin
                n_checks++; if (instr_out !== w[r / 4]) begin n_fail++; $display("FAIL full_order r=%0d got %h exp %h", r, instr_out, w[r / 4]); end
            end
        end
        n_checks++; if (issued_cnt !== 16'(DEPTH)) begin n_fail++; $display("FAIL full_issued got %0d exp %0d", issued_cnt, DEPTH); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL full_idle got %b exp 1", idle); end
        n_checks++; if (instr_out !== w[DEPTH-1]) begin n_fail++; $display("FAIL full_last got %h exp %h", instr_out, w[DEPTH-1]); end
    endtask

    task automatic test_pause();
        logic [12:0] w [4];
        w[0] = 13'h0001; w[1] = 13'h0202; w[2] = 13'h0403; w[3] = 13'h0604;
        apply_reset();
        for (int t = 0; t <= 12; t++) begin
            @(negedge clk);
            run = (t < 6) || (t >= 12);
            push_valid = (t < 4);
            if (t < 4) push_instr = w[t];
            @(posedge clk); #1;
            if (t == 8) begin
                n_checks++; if (instr_out !== w[1] || issuing !== 1'b1) begin n_fail++; $display("FAIL pause_dwell2 got %h/%b exp %h/1", instr_out, issuing, w[1]); end
            end
            if (t >= 9 && t <= 11) begin
                n_checks++; if (instr_out !== w[1]) begin n_fail++; $display("FAIL pause_hold t=%0d got %h exp %h", t, instr_out, w[1]); end
                n_checks++; if (issuing !== 1'b0) begin n_fail++; $display("FAIL pause_issuing t=%0d got %b exp 0", t, issuing); end
                n_checks++; if (fifo_count !== 5'd2) begin n_fail++; $display("FAIL pause_count t=%0d got %0d exp 2", t, fifo_count); end
                n_checks++; if (issued_cnt !== 16'd2) begin n_fail++; $display("FAIL pause_issued t=%0d got %0d exp 2", t, issued_cnt); end
            end
            if (t == 12) begin
                n_checks++; if (instr_out !== w[2]) begin n_fail++; $display("FAIL pause_resume got %h exp %h", instr_out, w[2]); end
                n_checks++; if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL pause_resume_count got %0d exp 1", fifo_count); end
            end
        end
        push_valid = 1'b0;
    endtask

    task automatic test_raw_stall();
        logic [12:0] w [4];
        int d [4];
        int s [4];
        int n_c10, n_a10, last_t;
        logic [12:0] exp_w;
        logic exp_iss;
        w = '{13'h1000, 13'h0C10, 13'h1000, 13'h0A10};
        d[0] = HOLD; d[1] = HOLD; d[2] = HOLD; d[3] = HOLD;
`ifdef VSEQ_RAW_STALL_EN
        d[1] = HOLD + 2;
`endif
        s[0] = 1;
        for (int k = 1; k < 4; k++) s[k] = s[k-1] + d[k-1];
        last_t = s[3] + d[3];
        n_c10 = 0; n_a10 = 0;
        apply_reset();
        run = 1'b1;
        for (int t = 0; t <= last_t; t++) begin
            @(negedge clk);
            push_valid = (t < 4);
            if (t < 4) push_instr = w[t];
            @(posedge clk); #1;
            exp_w = 13'h0;
            for (int k = 0; k < 4; k++) if (s[k] <= t) exp_w = w[k];
            exp_iss = (t >= 1) && (t < last_t);
            n_checks++; if (instr_out !== exp_w) begin n_fail++; $display("FAIL raw_instr_out t=%0d got %h exp %h", t, instr_out, exp_w); end
            n_checks++; if (issuing !== exp_iss) begin n_fail++; $display("FAIL raw_issuing t=%0d got %b exp %b", t, issuing, exp_iss); end
            if (issuing && instr_out == 13'h0C10) n_c10++;
            if (issuing && instr_out == 13'h0A10) n_a10++;
        end
        push_valid = 1'b0;
        n_checks++; if (n_c10 !== d[1]) begin n_fail++; $display("FAIL raw_store_r2_dwell got %0d exp %0d", n_c10, d[1]); end
        n_checks++; if (n_a10 !== d[3]) begin n_fail++; $display("FAIL raw_store_r1_dwell got %0d exp %0d", n_a10, d[3]); end
        n_checks++; if (issued_cnt !== 16'd4) begin n_fail++; $display("FAIL raw_issued got %0d exp 4", issued_cnt); end
    endtask

    task automatic test_counter_wrap();
        int exp_done;
        logic [12:0] exp_w;
        apply_reset();
        w_run = 1'b1;
        for (int t = 0; t <= 18; t++) begin
            @(negedge clk);
            w_push_valid = (t < 17);
            w_push_instr = 13'(t + 1);
            @(posedge clk); #1;
            exp_done = (t < 2) ? 0 : ((t - 1 < 17) ? t - 1 : 17);
            exp_w = (t == 0) ? 13'h0 : ((t <= 17) ? 13'(t) : 13'd17);
            n_checks++; if (w_issued_cnt !== 4'(exp_done)) begin n_fail++; $display("FAIL wrap_issued t=%0d got %0d exp %0d", t, w_issued_cnt, exp_done % 16); end
            n_checks++; if (w_instr_out !== exp_w) begin n_fail++; $display("FAIL wrap_instr_out t=%0d got %h exp %h", t, w_instr_out, exp_w); end
            n_checks++; if (w_fifo_count !== ((t < 17) ? 5'd1 : 5'd0)) begin n_fail++; $display("FAIL wrap_count t=%0d got %0d", t, w_fifo_count); end
            n_checks++; if (w_issuing !== (t >= 1 && t < 18)) begin n_fail++; $display("FAIL wrap_issuing t=%0d got %b", t, w_issuing); end
            n_checks++; if (w_push_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready t=%0d got %b exp 1", t, w_push_ready); end
        end
        w_push_valid = 1'b0;
        n_checks++; if (w_idle !== 1'b1) begin n_fail++; $display("FAIL wrap_idle got %b exp 1", w_idle); end
    endtask

    // Schedule model: entry i pops at max(push_edge+1, end of entry i-1)
    // and completes after its dwell; outputs follow from that schedule.
    task automatic test_random();
        logic [12:0] ew [$];
        int ep [$];
        int es [$];
        int ee [$];
        int cnt_before, exp_cnt, exp_done, k, d, s, prev_end;
        logic want, prev_alu, exp_iss, exp_idle;
        logic [12:0] word, exp_w;
        apply_reset();
        run = 1'b1;
        for (int e = 0; e < 400; e++) begin
            @(negedge clk);
            cnt_before = 0;
            for (int i = 0; i < ep.size(); i++) begin
                if (ep[i] <= e - 1) cnt_before++;
                if (es[i] <= e - 1) cnt_before--;
            end
            n_checks++; if (push_ready !== (cnt_before != DEPTH)) begin n_fail++; $display("FAIL rnd_push_ready e=%0d got %b model_count %0d", e, push_ready, cnt_before); end
            want = (e < 120) && ($urandom_range(0, 2) != 0);
            word = 13'($urandom);
            push_valid = want;
            push_instr = word;
            if (want && cnt_before != DEPTH) begin
                k = ew.size();
                prev_end = (k == 0) ? -1 : ee[k-1];
                prev_alu = (k == 0) ? 1'b0 : ew[k-1][12];
                s = (e + 1 > prev_end) ? e + 1 : prev_end;
                d = HOLD;
`ifdef VSEQ_RAW_STALL_EN
                if (word[12:11] == 2'b01 && word[10] && prev_alu) d = HOLD + 2;
`else
                if (prev_alu && 1'b0) d = HOLD;
`endif
                ew.push_back(word); ep.push_back(e); es.push_back(s); ee.push_back(s + d);
            end
            @(posedge clk); #1;
            exp_w = 13'h0; exp_iss = 1'b0; exp_done = 0; exp_cnt = 0;
            for (int i = 0; i < ew.size(); i++) begin
                if (es[i] <= e) exp_w = ew[i];
                if (es[i] <= e && e < ee[i]) exp_iss = 1'b1;
                if (ee[i] <= e) exp_done++;
                if (ep[i] <= e) exp_cnt++;
                if (es[i] <= e) exp_cnt--;
            end
            exp_idle = (exp_cnt == 0) && !exp_iss;
            n_checks++; if (instr_out !== exp_w) begin n_fail++; $display("FAIL rnd_instr_out e=%0d got %h exp %h", e, instr_out, exp_w); end
            n_checks++; if (issuing !== exp_iss) begin n_fail++; $display("FAIL rnd_issuing e=%0d got %b exp %b", e, issuing, exp_iss); end
            n_checks++; if (fifo_count !== 5'(exp_cnt)) begin n_fail++; $display("FAIL rnd_fifo_count e=%0d got %0d exp %0d", e, fifo_count, exp_cnt); end
            n_checks++; if (issued_cnt !== 16'(exp_done)) begin n_fail++; $display("FAIL rnd_issued_cnt e=%0d got %0d exp %0d", e, issued_cnt, exp_done); end
            n_checks++; if (idle !== exp_idle) begin n_fail++; $display("FAIL rnd_idle e=%0d got %b exp %b", e, idle, exp_idle); end
        end
        push_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        push_valid = 1'b0; push_instr = '0; run = 1'b0;
        w_push_valid = 1'b0; w_push_instr = '0; w_run = 1'b0;
        test_reset();
        test_back_to_back();
        test_reset_mid_dwell();
        test_full_fifo();
        test_pause();
        test_raw_stall();
        test_counter_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
